// File: rtl/smg_pkg.sv
// Shared constants, FSM state encoding and hex segment table for the
// seven-segment frame controller.
package smg_pkg;

    localparam logic [7:0] HDR        = 8'hAA;
    localparam logic [7:0] ADDR_CLR   = 8'hFF;
    localparam logic [4:0] BLANK_CODE = 5'h10;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_ADDR = 2'd1,
        GET_DATA = 2'd2,
        GET_CHK  = 2'd3
    } state_t;

    // Active-low gfedcba patterns for hex digits 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/smg_hex_decode.sv
// Combinational 5-bit digit code to active-low segment pattern.
// Code bit 4 set means blank; bits 3:0 select the hex glyph.
module smg_hex_decode
    import smg_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = code[4] ? SEG_BLANK : HEX_SEG[code[3:0]];
    end

endmodule

// File: rtl/smg_frame_ctrl.sv
// UART frame parser (AA, ADDR, DATA, CHK) feeding an 8-digit buffer that is
// scanned onto a multiplexed seven-segment display. Optional macro:
// SMG_LEAD_ZERO_BLANK_EN suppresses leading zeros on the display path.
module smg_frame_ctrl
    import smg_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] seg_sel,
    output logic [6:0] seg_ment,
    output logic       frame_ok,
    output logic       frame_err
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [7:0]       addr_q;
    logic [7:0]       data_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [4:0]       digit_buf [8];
    logic [2:0]       scan_idx;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       disp_code;
    logic [6:0]       disp_seg;
    logic             timeout;
    logic             chk_ok;

    // A timeout takes priority over a byte strobed in the same cycle.
    assign timeout = (state != IDLE) && (gap_cnt == GAP_LAST);
    assign chk_ok  = (rx_data == (addr_q ^ data_q));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            gap_cnt   <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            // NOTE: the digit buffer is reset because blank is the visible
            // power-up state, unlike a plain data memory.
            for (int i = 0; i < 8; i++) digit_buf[i] <= BLANK_CODE;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (timeout) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                gap_cnt   <= '0;
            end else begin
                if (state != IDLE) gap_cnt <= rx_valid ? '0 : gap_cnt + 1'b1;
                if (rx_valid) begin
                    case (state)
                        IDLE: begin
                            if (rx_data == HDR) begin
                                state   <= GET_ADDR;
                                gap_cnt <= '0;
                            end
                        end
                        GET_ADDR: begin
                            addr_q <= rx_data;
                            state  <= GET_DATA;
                        end
                        GET_DATA: begin
                            data_q <= rx_data;
                            state  <= GET_CHK;
                        end
                        GET_CHK: begin
                            state <= IDLE;
                            if (!chk_ok) begin
                                frame_err <= 1'b1;
                            end else if (addr_q < 8'd8) begin
                                digit_buf[addr_q[2:0]] <= data_q[4:0];
                                frame_ok <= 1'b1;
                            end else if (addr_q == ADDR_CLR) begin
                                for (int i = 0; i < 8; i++) digit_buf[i] <= BLANK_CODE;
                                frame_ok <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    // NOTE: combinational blocks assign a default first so no latch is inferred.
    always_comb begin
        disp_code = digit_buf[scan_idx];
`ifdef SMG_LEAD_ZERO_BLANK_EN
        begin : lead_zero
            logic higher_zero;
            higher_zero = 1'b1;
            for (int i = 1; i < 8; i++) begin
                if (i > int'(scan_idx) && !(digit_buf[i] == 5'h00 || digit_buf[i][4]))
                    higher_zero = 1'b0;
            end
            if (scan_idx != 3'd0 && higher_zero && disp_code == 5'h00)
                disp_code = BLANK_CODE;
        end
`endif
    end

    smg_hex_decode u_hex_decode (
        .code (disp_code),
        .seg  (disp_seg)
    );

    // Outputs lag the scan index by one cycle and pick up buffer writes the
    // cycle after they land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            scan_idx <= 3'd0;
            seg_sel  <= 8'hFE;
            seg_ment <= SEG_BLANK;
        end else begin
            seg_sel  <= ~(8'd1 << scan_idx);
            seg_ment <= disp_seg;
            if (div_cnt == DIV_LAST) begin
                div_cnt  <= '0;
                scan_idx <= scan_idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_smg_frame_ctrl.sv
// Self-checking bench for smg_frame_ctrl: directed frames plus randomized
// traffic compared every cycle against a frame/queue-level reference model.
module tb_smg_frame_ctrl;

    localparam int SCAN_DIV    = 4;
    localparam int TIMEOUT_CYC = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] seg_sel;
    logic [6:0] seg_ment;
    logic       frame_ok;
    logic       frame_err;

    smg_frame_ctrl #(
        .SCAN_DIV    (SCAN_DIV),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .seg_sel   (seg_sel),
        .seg_ment  (seg_ment),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [4:0] m_buf [8];
    logic [7:0] m_q [$];
    int         m_cycles;
    bit         m_in_frame;
    int         m_idle;
    logic [7:0] exp_sel;
    logic [6:0] exp_ment;
    logic       exp_ok;
    logic       exp_err;

    function automatic logic [6:0] m_disp(int i);
        logic [4:0] c;
        c = m_buf[i];
        if (c[4]) return 7'h7F;
`ifdef SMG_LEAD_ZERO_BLANK_EN
        if (i != 0 && c == 5'h00) begin
            bit all_zero = 1'b1;
            for (int j = i + 1; j < 8; j++)
                if (!(m_buf[j] == 5'h00 || m_buf[j][4])) all_zero = 1'b0;
            if (all_zero) return 7'h7F;
        end
`endif
        return seg_tab[c[3:0]];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_buf[i] = 5'h10;
        m_q.delete();
        m_cycles   = 0;
        m_in_frame = 1'b0;
        m_idle     = 0;
    endtask

    // Predicts outputs visible after the next clock edge for this cycle's input.
    task automatic model_step(input logic v, input logic [7:0] d);
        int idx;
        logic [7:0] a, dat, c;
        idx      = (m_cycles / SCAN_DIV) % 8;
        exp_sel  = ~(8'd1 << idx);
        exp_ment = m_disp(idx);
        m_cycles++;
        exp_ok  = 1'b0;
        exp_err = 1'b0;
        if (m_in_frame && m_idle >= TIMEOUT_CYC - 1) begin
            exp_err    = 1'b1;
            m_in_frame = 1'b0;
        end else if (v) begin
            if (!m_in_frame) begin
                if (d == 8'hAA) begin
                    m_in_frame = 1'b1;
                    m_q.delete();
                    m_idle = 0;
                end
            end else begin
                m_q.push_back(d);
                m_idle = 0;
                if (m_q.size() == 3) begin
                    m_in_frame = 1'b0;
                    a = m_q[0]; dat = m_q[1]; c = m_q[2];
                    if ((a ^ dat) != c) exp_err = 1'b1;
                    else if (a < 8) begin
                        m_buf[a] = dat[4:0];
                        exp_ok = 1'b1;
                    end else if (a == 8'hFF) begin
                        for (int i = 0; i < 8; i++) m_buf[i] = 5'h10;
                        exp_ok = 1'b1;
                    end else exp_err = 1'b1;
                end
            end
        end else if (m_in_frame) begin
            m_idle++;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge: drive, predict, let the rising edge pass, compare.
    task automatic cycle(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        model_step(v, d);
        @(posedge clk);
        @(negedge clk);
        check("seg_sel", seg_sel, exp_sel);
        check("seg_ment", {1'b0, seg_ment}, {1'b0, exp_ment});
        check("frame_ok", {7'd0, frame_ok}, {7'd0, exp_ok});
        check("frame_err", {7'd0, frame_err}, {7'd0, exp_err});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        cycle(1'b1, d);
        idle(gap);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hAA, 1);
        send_byte(a, 0);
        send_byte(d, 2);
        send_byte(c, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sel"}, seg_sel, 8'hFE);
        check({tag, "_ment"}, {1'b0, seg_ment}, 8'h7F);
        check({tag, "_ok"}, {7'd0, frame_ok}, 8'h00);
        check({tag, "_err"}, {7'd0, frame_err}, 8'h00);
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, releases at a falling edge.
    task automatic apply_reset(input string tag);
        rx_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset_vals(tag);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_vals({tag, "_hold"});
        rst_n = 1'b1;
    endtask

    function automatic int rgap();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(17, 21));
        return int'($urandom_range(0, 3));
    endfunction

    logic [7:0] r_addr, r_data, r_chk, r_noise;
    int         r_sel;

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;

        idle(40);                                   // full scan with blank digits
        send_frame(8'h03, 8'h05, 8'h06); idle(40);  // digit 3 = 5
        send_frame(8'h02, 8'h0A, 8'h09); idle(8);   // bad checksum
        send_frame(8'h09, 8'h01, 8'h08); idle(8);   // bad address
        send_byte(8'hAA, 0); send_byte(8'h01, 20);  // timeout
        send_frame(8'h01, 8'h0F, 8'h0E); idle(40);
        // Gap boundary: 18 idle cycles survive, 19 idle cycles time out.
        send_byte(8'hAA, 0); send_byte(8'h04, 18); send_byte(8'h05, 0); send_byte(8'h01, 4);
        send_byte(8'hAA, 0); send_byte(8'h04, 19); send_byte(8'h05, 0); send_byte(8'h01, 4);
        send_frame(8'h06, 8'hAA, 8'hAC); idle(8);   // header value as data
        // Leading-zero pattern, then clear-all.
        for (int i = 0; i < 8; i++) send_frame(8'(i), (i == 5) ? 8'h01 : 8'h00, (i == 5) ? 8'(i) ^ 8'h01 : 8'(i));
        idle(40);
        send_frame(8'hFF, 8'h00, 8'hFF); idle(40);
        // Reset in the middle of a frame discards it.
        send_frame(8'h00, 8'h07, 8'h07);
        send_byte(8'hAA, 0); send_byte(8'h05, 1);
        apply_reset("midrst");
        send_byte(8'h00, 1); idle(40);

        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                r_noise = 8'($urandom_range(0, 255));
                if (r_noise == 8'hAA) r_noise = 8'h55;
                send_byte(r_noise, int'($urandom_range(0, 2)));
            end
            r_sel  = int'($urandom_range(0, 9));
            r_addr = (r_sel < 7) ? 8'($urandom_range(0, 7)) :
                     (r_sel == 7) ? 8'hFF : 8'($urandom_range(8, 254));
            r_data = ($urandom_range(0, 7) == 0) ? 8'hAA : 8'($urandom_range(0, 255));
            r_chk  = r_addr ^ r_data;
            if ($urandom_range(0, 5) == 0) r_chk = r_chk ^ 8'($urandom_range(1, 255));
            send_byte(8'hAA, rgap());
            send_byte(r_addr, rgap());
            send_byte(r_data, rgap());
            send_byte(r_chk, int'($urandom_range(0, 6)));
            if (f % 50 == 49) idle(36);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/smg_frame_ctrl.md
Name: smg_frame_ctrl

Overview:
- Command parser and scan scheduler between the UART receiver and the 8-digit seven-segment display.
- Accepts received bytes and decodes 4-byte write frames into an 8-entry digit buffer.
- Time-multiplexes the buffer onto seg_sel/seg_ment.
- Replaces direct byte-to-display wiring, so any digit can be written individually from the host.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit is driven (1 ms at 50 MHz); minimum 2.
- TIMEOUT_CYC, 500000, maximum idle clk cycles between bytes inside a frame before abort.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. Asynchronous assert, active-low.
- rx_valid  input  1  one-cycle strobe; rx_data holds a new byte.
- rx_data  input  8  received byte.
- seg_sel  output  8  digit select, active-low one-hot; bit i = digit i.
- seg_ment  output  7  segments gfedcba, active-low.
- frame_ok  output  1  one-cycle pulse when a frame commits.
- frame_err  output  1  one-cycle pulse on checksum error, bad address or timeout.

Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values:
  - state=IDLE.
  - All 8 buffer entries = blank (bit4 set).
  - scan index=0, divider=0.
  - seg_sel=8'hFE, seg_ment=7'h7F.
  - frame_ok=0, frame_err=0.
- Frame format: 0xAA, ADDR, DATA, CHK, with CHK = ADDR ^ DATA.
- ADDR values:
  - 0x00-0x07: write digit ADDR with DATA[4:0]. Bit4=1 means blank; bits3:0 are the hex value.
  - 0xFF: clear all digits to blank. DATA is ignored but still included in the checksum.
  - Any other value: frame_err is pulsed after CHK, and nothing is written.
- FSM states: IDLE, GET_ADDR, GET_DATA, GET_CHK.
  - IDLE: on rx_valid with 0xAA go to GET_ADDR; other bytes are ignored silently.
  - GET_ADDR: latch the byte, then go to GET_DATA.
  - GET_DATA: latch the byte, then go to GET_CHK.
  - GET_CHK, checksum good: commit on the cycle after the CHK strobe, pulse frame_ok, return to IDLE.
  - GET_CHK, checksum bad: pulse frame_err, return to IDLE.
- No resync on 0xAA mid-frame: 0xAA received as ADDR/DATA/CHK is treated as data.
- Timeout:
  - A gap counter runs in every non-IDLE state and is cleared on each rx_valid.
  - On reaching TIMEOUT_CYC-1: pulse frame_err, go to IDLE, no write.
- Scan:
  - The divider counts 0..SCAN_DIV-1.
  - On wrap, the scan index advances, wrapping 7->0.
  - seg_sel and seg_ment are registered: one cycle after the index changes, both reflect the new digit.
  - Hex decode (active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E. Blank = 7F.
- Simultaneous commit and scan of the same digit:
  - The buffer write takes effect at the clock edge.
  - seg_ment shows the new value starting with the next registered output, with no glitch beyond one cycle.
- rx_valid in the same cycle as a timeout: the timeout wins, and the byte is dropped.
- Reset mid-frame: everything returns to reset values immediately; partial frames are discarded.

Optional Feature:
- Macro: SMG_LEAD_ZERO_BLANK_EN.
- Defined: when a digit is displayed, if its value is 0 and all higher-index digits are 0 or blank, it is shown blank (7F). Digit 0 is never suppressed. The buffer contents are unchanged.
- Undefined: digits are displayed exactly as stored.

Decomposition:
- smg_pkg holds:
  - localparams HDR=8'hAA, ADDR_CLR=8'hFF, BLANK_CODE=5'h10.
  - The FSM state encoding (2 bits).
  - The 16-entry decode constants.
- Sub-module smg_hex_decode: combinational 5-bit code -> 7-bit active-low segments. Instanced once on the scan path.
- Everything else (FSM, buffer, scan) lives in smg_frame_ctrl.

Test Plan (benches use SCAN_DIV=4, TIMEOUT_CYC=20):
- Reset release, no input -> seg_sel cycles FE,FD,FB,…,7F every 4 cycles; seg_ment=7F throughout; no pulses.
- Frame AA 03 05 06 -> frame_ok pulse 1 cycle after CHK; whenever seg_sel=F7, seg_ment=12.
- Frame AA 02 0A 09 (bad CHK, should be 08) -> frame_err pulse; digit 2 stays blank.
- Frame AA 09 01 08 -> frame_err (bad address); no buffer change.
- AA 01, then 20 idle cycles -> frame_err at the timeout; next frame AA 01 0F 0E is accepted and digit 1 shows 0E.
- Digits 7..0 written 00,00,01,00,00,00,00,00, then frame AA FF 00 FF -> frame_ok, all digits 7F.
- With SMG_LEAD_ZERO_BLANK_EN defined: digits 7 and 6 show 7F; digit 5 shows 79; digits 4..0 show 40.
- Without SMG_LEAD_ZERO_BLANK_EN: digits 7 and 6 show 40.
